// File: rtl/alu_pkg.sv
// Shared constants for the demo-board ALU: opcodes, data width and operand tables.
// DEBOUNCE_CYCLES exists only when ALU_DEBOUNCE_EN is defined.
package alu_pkg;

    localparam int DATA_W = 8;

`ifdef ALU_DEBOUNCE_EN
    localparam int DEBOUNCE_CYCLES = 16;
    localparam int DB_CNT_W        = $clog2(DEBOUNCE_CYCLES + 1);
`endif

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_NAND  = 4'h8;
    localparam logic [3:0] OP_NOR   = 4'h9;
    localparam logic [3:0] OP_XNOR  = 4'hA;
    localparam logic [3:0] OP_SHL   = 4'hB;
    localparam logic [3:0] OP_SHR   = 4'hC;
    localparam logic [3:0] OP_ROL   = 4'hD;
    localparam logic [3:0] OP_ROR   = 4'hE;
    localparam logic [3:0] OP_PASSB = 4'hF;

    // Leftmost entry is index 0.
    localparam logic [0:7][DATA_W-1:0] OPERAND_A_TABLE = {
        8'h00, 8'h0F, 8'h3C, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF
    };
    localparam logic [0:7][DATA_W-1:0] OPERAND_B_TABLE = {
        8'h01, 8'h0F, 8'hF0, 8'h55, 8'h80, 8'h33, 8'h7E, 8'hFF
    };

endpackage

// File: rtl/btn_edge.sv
// Push-button front end: 2-flop synchronizer, optional debounce (ALU_DEBOUNCE_EN),
// and a one-cycle pulse on each rising edge of the resulting level.
module btn_edge
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse_out
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_in;
            sync_2 <= sync_1;
        end
    end

`ifdef ALU_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] db_cnt;
    logic                db_level;

    // The count restarts whenever the synchronized input falls back to the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= sync_2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync_2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse_out = level & ~level_q;

endmodule

// File: rtl/alu_unit.sv
// Registered 8-bit ALU whose operands are picked from constant tables by button-stepped indices.
// Define ALU_DEBOUNCE_EN to debounce the select_a/select_b buttons.
module alu_unit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        select,
    input  logic              select_a,
    input  logic              select_b,
    output logic [DATA_W-1:0] out_put,
    output logic              carry_flag
);

    logic              pulse_a;
    logic              pulse_b;
    logic [2:0]        idx_a;
    logic [2:0]        idx_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res;
    logic              cy;

    btn_edge u_btn_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (select_a),
        .pulse_out (pulse_a)
    );

    btn_edge u_btn_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (select_b),
        .pulse_out (pulse_b)
    );

    // Indices are 3 bits wide, so 7 wraps to 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_a <= 3'd0;
            idx_b <= 3'd0;
        end else begin
            if (pulse_a) idx_a <= idx_a + 3'd1;
            if (pulse_b) idx_b <= idx_b + 3'd1;
        end
    end

    assign op_a = OPERAND_A_TABLE[idx_a];
    assign op_b = OPERAND_B_TABLE[idx_b];

    always_comb begin
        res = '0;
        cy  = 1'b0;
        case (select)
            OP_ADD:   {cy, res} = {1'b0, op_a} + {1'b0, op_b};
            OP_SUB:   {cy, res} = {1'b0, op_a} - {1'b0, op_b};
            OP_INC:   {cy, res} = {1'b0, op_a} + (DATA_W + 1)'(1);
            OP_DEC:   {cy, res} = {1'b0, op_a} - (DATA_W + 1)'(1);
            OP_AND:   res = op_a & op_b;
            OP_OR:    res = op_a | op_b;
            OP_XOR:   res = op_a ^ op_b;
            OP_NOT:   res = ~op_a;
            OP_NAND:  res = ~(op_a & op_b);
            OP_NOR:   res = ~(op_a | op_b);
            OP_XNOR:  res = ~(op_a ^ op_b);
            OP_SHL: begin
                res = {op_a[DATA_W-2:0], 1'b0};
                cy  = op_a[DATA_W-1];
            end
            OP_SHR: begin
                res = {1'b0, op_a[DATA_W-1:1]};
                cy  = op_a[0];
            end
            OP_ROL: begin
                res = {op_a[DATA_W-2:0], op_a[DATA_W-1]};
                cy  = op_a[DATA_W-1];
            end
            OP_ROR: begin
                res = {op_a[0], op_a[DATA_W-1:1]};
                cy  = op_a[0];
            end
            OP_PASSB: res = op_b;
            default: begin
                res = '0;
                cy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_put    <= '0;
            carry_flag <= 1'b0;
        end else begin
            out_put    <= res;
            carry_flag <= cy;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit (default build, no debounce).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] select = 4'h0;
    logic       select_a = 1'b0;
    logic       select_b = 1'b0;
    logic [7:0] out_put;
    logic       carry_flag;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_a    = 0;
    int mdl_b    = 0;
    int tab_a[8] = '{8'h00, 8'h0F, 8'h3C, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};
    int tab_b[8] = '{8'h01, 8'h0F, 8'hF0, 8'h55, 8'h80, 8'h33, 8'h7E, 8'hFF};
    logic [8:0] exp_v;

    alu_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .select     (select),
        .select_a   (select_a),
        .select_b   (select_b),
        .out_put    (out_put),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    // Reference ALU in plain integer arithmetic; returns {carry, result}.
    function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
        int r;
        int c;
        c = 0;
        case (op)
            0:  begin r = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  begin r = (a + 1) % 256;       c = (a == 255) ? 1 : 0; end
            3:  begin r = (a + 255) % 256;     c = (a == 0) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = 255 - a;
            8:  r = 255 - (a & b);
            9:  r = 255 - (a | b);
            10: r = 255 - (a ^ b);
            11: begin r = (a * 2) % 256;           c = (a >= 128) ? 1 : 0; end
            12: begin r = a / 2;                   c = a % 2; end
            13: begin r = (a * 2) % 256 + a / 128; c = (a >= 128) ? 1 : 0; end
            14: begin r = a / 2 + (a % 2) * 128;   c = a % 2; end
            default: r = b;
        endcase
        return {c[0], r[7:0]};
    endfunction

    task automatic press(input bit pa, input bit pb, input int hold);
        select_a = pa;
        select_b = pb;
        repeat (hold) @(negedge clk);
        select_a = 1'b0;
        select_b = 1'b0;
        repeat (4) @(negedge clk);
        if (pa) mdl_a = (mdl_a + 1) % 8;
        if (pb) mdl_b = (mdl_b + 1) % 8;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        select_a = 1'b0;
        select_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mdl_a = 0;
        mdl_b = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_state: got c=%0b out=%02h, want c=0 out=00", carry_flag, out_put);
        end
        rst_n  = 1'b1;
        select = 4'h0;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h001) begin
            n_fail++;
            $display("FAIL reset_add: got c=%0b out=%02h, want c=0 out=01", carry_flag, out_put);
        end
    endtask

    task automatic test_latency();
        select   = 4'h0;
        select_a = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h001) begin
            n_fail++;
            $display("FAIL latency_early: got c=%0b out=%02h, want c=0 out=01", carry_flag, out_put);
        end
        @(negedge clk);
        mdl_a = 1;
        n_checks++;
        if ({carry_flag, out_put} !== 9'h010) begin
            n_fail++;
            $display("FAIL latency_add: got c=%0b out=%02h, want c=0 out=10", carry_flag, out_put);
        end
        @(negedge clk);
        select_a = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h010) begin
            n_fail++;
            $display("FAIL held_once: got c=%0b out=%02h, want c=0 out=10", carry_flag, out_put);
        end
    endtask

    task automatic test_sub_pass();
        do_reset();
        select = 4'h1;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL sub_borrow: got c=%0b out=%02h, want c=1 out=FF", carry_flag, out_put);
        end
        select = 4'hF;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h001) begin
            n_fail++;
            $display("FAIL pass_b: got c=%0b out=%02h, want c=0 out=01", carry_flag, out_put);
        end
    endtask

    task automatic test_inc_dec_wrap();
        do_reset();
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, $urandom_range(1, 8));
        select = 4'h2;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h100) begin
            n_fail++;
            $display("FAIL inc_ff: got c=%0b out=%02h, want c=1 out=00", carry_flag, out_put);
        end
        press(1'b1, 1'b0, 2);
        select = 4'h3;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL dec_wrap: got c=%0b out=%02h, want c=1 out=FF", carry_flag, out_put);
        end
    endtask

    task automatic test_shifts();
        do_reset();
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, $urandom_range(1, 8));
        select = 4'hB;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h100) begin
            n_fail++;
            $display("FAIL shl_80: got c=%0b out=%02h, want c=1 out=00", carry_flag, out_put);
        end
        select = 4'hD;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h101) begin
            n_fail++;
            $display("FAIL rol_80: got c=%0b out=%02h, want c=1 out=01", carry_flag, out_put);
        end
        select = 4'hC;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h040) begin
            n_fail++;
            $display("FAIL shr_80: got c=%0b out=%02h, want c=0 out=40", carry_flag, out_put);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(1'b1, 1'b1, 3);
        select = 4'h6;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h000) begin
            n_fail++;
            $display("FAIL dual_xor: got c=%0b out=%02h, want c=0 out=00", carry_flag, out_put);
        end
        select = 4'h0;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h01E) begin
            n_fail++;
            $display("FAIL dual_add: got c=%0b out=%02h, want c=0 out=1E", carry_flag, out_put);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({carry_flag, out_put} !== 9'h000) begin
            n_fail++;
            $display("FAIL async_reset: got c=%0b out=%02h, want c=0 out=00", carry_flag, out_put);
        end
        mdl_a = 0;
        mdl_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({carry_flag, out_put} !== 9'h001) begin
            n_fail++;
            $display("FAIL post_reset_idx: got c=%0b out=%02h, want c=0 out=01", carry_flag, out_put);
        end
    endtask

    task automatic test_random();
        int kind;
        int op;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if (kind != 3) press(kind != 1, kind != 0, $urandom_range(1, 12));
            for (int k = 0; k < 2; k++) begin
                op     = $urandom_range(0, 15);
                select = op[3:0];
                @(negedge clk);
                exp_v = ref_alu(op, tab_a[mdl_a], tab_b[mdl_b]);
                n_checks++;
                if ({carry_flag, out_put} !== exp_v) begin
                    n_fail++;
                    $display("FAIL random op=%0h ia=%0d ib=%0d: got c=%0b out=%02h, want c=%0b out=%02h",
                             op, mdl_a, mdl_b, carry_flag, out_put, exp_v[8], exp_v[7:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sub_pass();
        test_inc_dec_wrap();
        test_shifts();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
